// File: rtl/drp_sample_responder.sv
// drp_sample_responder: DRP slave exposing 16 aux-channel result registers (0x10-0x1F) fed by an external sampler.
// Ports:
//   CLK, RESETN                       clock, asynchronous active-low reset
//   sample_valid/chan/data            1-cycle sample strobe, aux channel, 12-bit result
//   daddr_in, den_in, dwe_in, di_in   DRP request (address, enable, write enable, write data)
//   do_out, drdy_out                  DRP read data (zero unless drdy_out) and completion pulse
//   eoc_out, channel_out              end-of-conversion pulse and {1'b1, channel} of last eoc
//   busy_out, err_out                 transaction outstanding, sticky overlap error
//   alarm_out                         OR of per-channel threshold alarms
// Optional feature: define DRP_RESP_ALARM_EN for the 0x50 threshold register and alarm_out.
module drp_sample_responder #(
  parameter int          RD_LATENCY = 2,
  parameter logic [15:0] CH_MASK    = 16'h0303
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        sample_valid,
  input  logic [3:0]  sample_chan,
  input  logic [11:0] sample_data,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        eoc_out,
  output logic [4:0]  channel_out,
  output logic        busy_out,
  output logic        err_out,
  output logic        alarm_out
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  // WAIT lasts RD_LATENCY-1 cycles; the counter runs down to zero inclusive.
  localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] res_q [16];
  logic [15:0] rd_q, do_q, rdata;
  logic        drdy_q, busy_q, err_q, eoc_q;
  logic [4:0]  chan_q;
  logic        wr;
  assign wr = sample_valid & CH_MASK[sample_chan];
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      res_q  <= '{default: '0};
      eoc_q  <= 1'b0;
      chan_q <= '0;
    end else begin
      eoc_q <= wr;
      if (wr) begin
        res_q[sample_chan] <= {sample_data, 4'h0};
        chan_q             <= {1'b1, sample_chan};
      end
    end
  end
`ifdef DRP_RESP_ALARM_EN
  logic [15:0] thr_q, alm_q;
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      thr_q <= 16'hFFF0;
      alm_q <= '0;
    end else begin
      if (state_q == IDLE && den_in && dwe_in && daddr_in == 7'h50) thr_q <= di_in;
      if (wr) alm_q[sample_chan] <= {sample_data, 4'h0} > thr_q;
    end
  end
  assign alarm_out = |alm_q;
  // Bank is read with its pre-edge value, so a same-cycle sample write is not seen.
  assign rdata = daddr_in[6:4] == 3'b001 ? res_q[daddr_in[3:0]] :
                 daddr_in == 7'h50       ? thr_q : '0;
`else
  logic unused_di;
  assign unused_di = ^di_in;
  assign alarm_out = 1'b0;
  assign rdata     = daddr_in[6:4] == 3'b001 ? res_q[daddr_in[3:0]] : '0;
`endif
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      do_q    <= '0;
      drdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (den_in && busy_q) err_q <= 1'b1;
      case (state_q)
        IDLE: if (den_in) begin
          busy_q <= 1'b1;
          rd_q   <= dwe_in ? '0 : rdata;
          cnt_q  <= CNT_LOAD;
          if (RD_LATENCY == 1) begin
            state_q <= RESP;
            drdy_q  <= 1'b1;
            do_q    <= dwe_in ? '0 : rdata;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: if (cnt_q == 0) begin
          state_q <= RESP;
          drdy_q  <= 1'b1;
          do_q    <= rd_q;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: begin
          state_q <= IDLE;
          drdy_q  <= 1'b0;
          do_q    <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign do_out      = do_q;
  assign drdy_out    = drdy_q;
  assign busy_out    = busy_q;
  assign err_out     = err_q;
  assign eoc_out     = eoc_q;
  assign channel_out = chan_q;
endmodule
